// File: rtl/wb_master_pkg.sv
// ---------------------------------------------------------------------------
// wb_master_pkg
// Shared definitions for the single-transaction Wishbone master sequencer:
//   - state_t            : sequencer FSM state encoding
//   - TIMEOUT_CYCLES_DEF : default number of bus cycles to wait for an ack
//   - TMO_CNT_W          : width of the timeout counter (covers 1..255)
// ---------------------------------------------------------------------------
package wb_master_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
  localparam int unsigned TMO_CNT_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// ---------------------------------------------------------------------------
// wb_timeout_counter
// Counts bus cycles that ended without an acknowledge.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (held while the master is not on the bus)
//   enable     : count this cycle (bus cycle without ack)
//   expired    : the current bus cycle is the last one allowed before abort
// ---------------------------------------------------------------------------
module wb_timeout_counter
  import wb_master_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // count_r holds the number of completed unacknowledged bus cycles, so when
  // it equals LIMIT-1 the cycle in progress is the LIMIT-th one.
  localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);

  logic [TMO_CNT_W-1:0] count_r;

  // Unacknowledged-cycle counter, saturating at LAST so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {TMO_CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {TMO_CNT_W{1'b0}};
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + TMO_CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/wb_master_seq.sv
// ---------------------------------------------------------------------------
// wb_master_seq
// Turns one command (valid/ready) into one classic Wishbone cycle and returns
// one response (valid/ready). At most one transaction is in flight. A cycle
// without ack for TIMEOUT_CYCLES bus cycles is aborted with rsp_err=1.
// Ports:
//   wb_clk_i, wb_rst_ni        : clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_we/adr/dat/sel : command channel
//   rsp_valid/ready, rsp_dat/err        : response channel
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o : registered Wishbone request
//   wbm_ack_i, wbm_dat_i       : Wishbone responder ack and read data
// ---------------------------------------------------------------------------
module wb_master_seq
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF,
  parameter logic [31:0] RESP_ON_WRITE_DATA = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  state_t      state_r, state_s;
  logic        cmd_ready_r, cmd_ready_s;
  logic        cyc_r, cyc_s;
  logic        we_r, we_s;
  logic [3:0]  sel_r, sel_s;
  logic [31:0] adr_r, adr_s;
  logic [31:0] dat_r, dat_s;
  logic        rsp_valid_r, rsp_valid_s;
  logic [31:0] rsp_dat_r, rsp_dat_s;
  logic        rsp_err_r, rsp_err_s;
  logic        cnt_clear_s, cnt_en_s, expired_s;

  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear   (cnt_clear_s),
    .enable  (cnt_en_s),
    .expired (expired_s)
  );

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_s     = state_r;
    cyc_s       = cyc_r;
    we_s        = we_r;
    sel_s       = sel_r;
    adr_s       = adr_r;
    dat_s       = dat_r;
    rsp_valid_s = rsp_valid_r;
    rsp_dat_s   = rsp_dat_r;
    rsp_err_s   = rsp_err_r;
    cnt_clear_s = 1'b1;
    cnt_en_s    = 1'b0;
    cmd_ready_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // cmd_ready_r gates acceptance so nothing is taken in the first
        // cycle out of reset, before cmd_ready has risen.
        if (cmd_valid && cmd_ready_r) begin
          state_s = ST_BUS;
          cyc_s   = 1'b1;
          we_s    = cmd_we;
          sel_s   = cmd_sel;
          adr_s   = cmd_adr;
          dat_s   = cmd_dat;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BUS: begin
        cnt_clear_s = 1'b0;
        // Ack is checked before expiry so a coincident ack completes normally.
        if (wbm_ack_i) begin
          state_s     = ST_RESP;
          rsp_valid_s = 1'b1;
          rsp_dat_s   = we_r ? RESP_ON_WRITE_DATA : wbm_dat_i;
          rsp_err_s   = 1'b0;
        end else if (expired_s) begin
          state_s     = ST_RESP;
          rsp_valid_s = 1'b1;
          rsp_dat_s   = 32'h0000_0000;
          rsp_err_s   = 1'b1;
        end else begin
          cnt_en_s = 1'b1;
        end
        // Request fields return to zero together with cyc.
        if (state_s != ST_BUS) begin
          cyc_s = 1'b0;
          we_s  = 1'b0;
          sel_s = 4'h0;
          adr_s = 32'h0000_0000;
          dat_s = 32'h0000_0000;
        end else begin
          cyc_s = 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_s     = ST_IDLE;
          rsp_valid_s = 1'b0;
          rsp_dat_s   = 32'h0000_0000;
          rsp_err_s   = 1'b0;
        end else begin
          state_s = ST_RESP;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        cyc_s       = 1'b0;
        we_s        = 1'b0;
        sel_s       = 4'h0;
        adr_s       = 32'h0000_0000;
        dat_s       = 32'h0000_0000;
        rsp_valid_s = 1'b0;
        rsp_dat_s   = 32'h0000_0000;
        rsp_err_s   = 1'b0;
      end
    endcase

    // Ready is registered from the next state, so it rises the cycle after
    // a response is consumed rather than in the consuming cycle.
    cmd_ready_s = (state_s == ST_IDLE);
  end

  // State and output registers; reset aborts any bus cycle without response.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      sel_r       <= 4'h0;
      adr_r       <= 32'h0000_0000;
      dat_r       <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= cmd_ready_s;
      cyc_r       <= cyc_s;
      we_r        <= we_s;
      sel_r       <= sel_s;
      adr_r       <= adr_s;
      dat_r       <= dat_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_dat_r   <= rsp_dat_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_dat   = rsp_dat_r;
  assign rsp_err   = rsp_err_r;
  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = cyc_r;
  assign wbm_we_o  = we_r;
  assign wbm_sel_o = sel_r;
  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = dat_r;

endmodule

// File: tb/tb_wb_master_seq.sv
// ---------------------------------------------------------------------------
// tb_wb_master_seq
// Self-checking bench for wb_master_seq (default parameters: timeout 16,
// write response data 0). Expected responses are queued when a command is
// issued and compared when the response is consumed.
// ---------------------------------------------------------------------------
module tb_wb_master_seq;

  localparam int TMO = 16;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic        ack;
  logic [31:0] dat_i;

  int   total;
  int   bad;
  exp_t sb_q[$];

  wb_master_seq dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_sel_o (sel),
    .wbm_adr_o (adr),
    .wbm_dat_o (dat_o),
    .wbm_ack_i (ack),
    .wbm_dat_i (dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full command/bus/response transaction.
  // ack_at: BUS cycle (1-based) in which the responder acks, 0 = never.
  task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int ack_at, input logic [31:0] rd,
                         input int hold);
    exp_t e;
    exp_t got_e;
    int   k;
    int   ncyc;
    int   exp_len;
    int   waited;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    if (ack_at >= 1 && ack_at <= TMO) begin
      e.dat = w ? 32'h0000_0000 : rd; e.err = 1'b0; exp_len = ack_at;
    end else begin
      e.dat = 32'h0000_0000; e.err = 1'b1; exp_len = TMO;
    end
    sb_q.push_back(e);
    tick();
    // Scramble the command inputs to prove the request fields were latched.
    cmd_valid = 1'b0; cmd_adr = ~a; cmd_dat = ~d; cmd_sel = ~s; cmd_we = ~w;
    chk_eq("ready_in_bus", cmd_ready, 0);
    k = 1; ncyc = 0;
    while (cyc && k < 40) begin
      ncyc++;
      chk_eq("bus_adr", adr, a);
      chk_eq("bus_dat", dat_o, d);
      chk_eq("bus_sel", {28'h0, sel}, {28'h0, s});
      chk_eq("bus_we", we, w);
      chk_eq("bus_stb", stb, 1);
      if (k == ack_at) begin
        ack = 1'b1; dat_i = rd;
      end else begin
        ack = 1'b0; dat_i = 32'h5A5A_5A5A;
      end
      tick();
      k++;
    end
    ack = 1'b0;
    chk_eq("bus_len", ncyc, exp_len);
    chk_eq("idle_stb", stb, 0);
    chk_eq("idle_adr", adr, 0);
    chk_eq("idle_dat", dat_o, 0);
    chk_eq("idle_sel", {28'h0, sel}, 0);
    chk_eq("idle_we", we, 0);
    chk_eq("rsp_valid_up", rsp_valid, 1);
    // Back-pressure: response must hold, commands and stray acks ignored.
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0; cmd_valid = 1'b1; ack = 1'b1; dat_i = 32'hFFFF_0000;
      tick();
      chk_eq("hold_valid", rsp_valid, 1);
      chk_eq("hold_dat", rsp_dat, e.dat);
      chk_eq("hold_err", rsp_err, e.err);
      chk_eq("hold_ready", cmd_ready, 0);
      chk_eq("hold_cyc", cyc, 0);
    end
    ack = 1'b0;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    chk_eq("rsp_valid_consume", rsp_valid, 1);
    chk_eq("sb_nonempty", sb_q.size() > 0, 1);
    if (sb_q.size() > 0) begin
      got_e = sb_q.pop_front();
      chk_eq("rsp_dat", rsp_dat, got_e.dat);
      chk_eq("rsp_err", rsp_err, got_e.err);
    end
    tick();
    chk_eq("rsp_consumed", rsp_valid, 0);
    chk_eq("no_accept_on_consume", cyc, 0);
    chk_eq("ready_after_consume", cmd_ready, 1);
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    // Ack while idle must not start anything.
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_eq("idle_ack_rsp", rsp_valid, 0);
    chk_eq("idle_ack_cyc", cyc, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    cmd_sel = 4'h0; rsp_ready = 1'b0; ack = 1'b0; dat_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_ready", cmd_ready, 0);
    chk_eq("rst_cyc", cyc, 0);
    chk_eq("rst_rsp_valid", rsp_valid, 0);
    chk_eq("rst_rsp_dat", rsp_dat, 0);
    chk_eq("rst_rsp_err", rsp_err, 0);
    chk_eq("rst_adr", adr, 0);
    rst_n = 1'b1;
    tick();
    chk_eq("ready_after_release", cmd_ready, 1);

    // write, ack in the 2nd BUS cycle
    run_txn(1'b1, 32'h3000_0000, 32'h0000_0003, 4'hF, 2, 32'h1111_2222, 0);
    // read, ack in the first BUS cycle
    run_txn(1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF, 1, 32'h00AB_CDEF, 0);
    // read, no ack: timeout, late acks during response hold
    run_txn(1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 0, 32'h0, 2);
    // read with 5 cycles of response back-pressure
    run_txn(1'b0, 32'h3000_0020, 32'h0000_0000, 4'h3, 5, 32'h1234_5678, 5);
    // ack coincident with the expiry cycle wins
    run_txn(1'b0, 32'h3000_0030, 32'h0000_0000, 4'hF, TMO, 32'hCAFE_F00D, 0);
    // ack one cycle too late: timeout
    run_txn(1'b0, 32'h3000_0040, 32'h0000_0000, 4'hF, TMO + 1, 32'hBAD0_BAD0, 1);
    // partial write
    run_txn(1'b1, 32'h3000_0050, 32'hA5A5_0F0F, 4'h6, 3, 32'h7777_7777, 0);

    // Reset during the third BUS cycle
    chk_eq("pre_rst_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0008; cmd_dat = 32'h55AA_55AA; cmd_sel = 4'hF;
    tick();
    cmd_valid = 1'b0;
    chk_eq("rbus_cyc1", cyc, 1);
    tick();
    tick();
    chk_eq("rbus_cyc3", cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_cyc", cyc, 0);
    chk_eq("arst_stb", stb, 0);
    chk_eq("arst_adr", adr, 0);
    chk_eq("arst_dat", dat_o, 0);
    chk_eq("arst_we", we, 0);
    chk_eq("arst_ready", cmd_ready, 0);
    chk_eq("arst_rsp_valid", rsp_valid, 0);
    tick();
    tick();
    chk_eq("held_rst_ready", cmd_ready, 0);
    rst_n = 1'b1;
    tick();
    chk_eq("rel_ready", cmd_ready, 1);
    chk_eq("rel_cyc", cyc, 0);
    for (int i = 0; i < 3; i++) begin
      chk_eq("rel_no_rsp", rsp_valid, 0);
      tick();
    end

    // Normal operation after reset
    run_txn(1'b0, 32'h3000_0060, 32'h0000_0000, 4'hF, 4, 32'h0BAD_F00D, 1);

    chk_eq("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
